chess_turn_controller: RTL
==========================

# chess_turn_controller

Turn sequencer and game clock for the timed chess game. Runs on the divided 10 Hz OutClock, decides whose turn it is, grants board input to the side to move, counts down each side's remaining time and ends the game on timeout or king capture. Its Player and TurnActive outputs gate the board-layout/move-validation datapath. That datapath returns MoveDone and KingCaptured pulses to this block.

## Interface
- TICKS_PER_SEC, 10: OutClock cycles per second of game time.
- TIME_SECONDS, 300: initial time per side, in seconds.
- TIME_WIDTH, 10: width of each time counter.
- INCREMENT_SECONDS, 2: per-move bonus; used only when the increment feature is compiled in.
- Reset and clock (already decided): reset resetApp, asynchronous, active-high; clock OutClock.
- OutClock  in  1  10 Hz game clock.
- resetApp  in  1  async active-high reset.
- StartGame  in  1  level; begins the game from IDLE.
- MoveDone  in  1  one-cycle pulse; current side has committed a legal move.
- KingCaptured  in  1  one-cycle pulse; current side's move captured the opposing king.
- Player  out  1  side to move: 1 = white, 0 = black.
- TurnActive  out  1  high while a side may move; the board ignores locks when low.
- WhiteTime  out  TIME_WIDTH  white seconds remaining.
- BlackTime  out  TIME_WIDTH  black seconds remaining.
- GameOver  out  1  game ended.
- Winner  out  1  valid when GameOver: 1 = white, 0 = black.

## Operation
- FSM states: IDLE, WHITE_TURN, BLACK_TURN, GAME_OVER.
- IDLE:
  - clocks frozen; TurnActive = 0.
  - StartGame = 1 -> WHITE_TURN.
  - MoveDone and KingCaptured are ignored.
- WHITE_TURN / BLACK_TURN:
  - TurnActive = 1.
  - Sub-second counter SubCnt runs 0..TICKS_PER_SEC-1.
  - At wrap, the mover's time decrements by 1.
- Priority per cycle (in a turn state), highest first: KingCaptured, then MoveDone, then timeout.
  - KingCaptured: -> GAME_OVER; Winner = current Player.
  - MoveDone: -> the other turn state; Player toggles; SubCnt clears to 0. Any decrement due in the same cycle is discarded.
  - Timeout: a decrement that makes the mover's time 0 -> GAME_OVER; Winner = opponent (~Player).
- GAME_OVER:
  - TurnActive = 0; GameOver = 1; times frozen.
  - All inputs ignored; only resetApp leaves this state.
- Time counters never decrement below 0. The idle side's counter holds.
- Player holds its last value in GAME_OVER.

## Timing
- Reset values:
  - state IDLE; Player 1; TurnActive 0; GameOver 0; Winner 0; SubCnt 0.
  - WhiteTime = BlackTime = TIME_SECONDS (truncated to TIME_WIDTH).
- All outputs are registered. Every transition is visible one OutClock edge after the sampled input.
- StartGame high at edge N -> TurnActive = 1 and SubCnt counting from edge N+1.
- The first white decrement occurs TICKS_PER_SEC edges after entering WHITE_TURN.
- MoveDone at edge N -> Player toggled at N+1. The new side's first decrement comes TICKS_PER_SEC edges later.
- Timeout: the edge that writes 0 into the mover's time also writes GameOver = 1.
- resetApp asserted mid-game:
  - immediately forces all reset values, regardless of the clock.
  - an in-flight MoveDone is lost.
- Deasserting resetApp returns the block to IDLE. StartGame must be sampled high after that.

## Configuration
- Macro: CHESS_TIME_INCREMENT_EN.
- Defined:
  - on an accepted MoveDone, the mover's time += INCREMENT_SECONDS, in the same edge as the Player toggle.
  - the sum saturates at 2^TIME_WIDTH-1.
  - the increment is not applied on KingCaptured.
- Undefined: no increment logic; INCREMENT_SECONDS is unused; times only decrease.

## Test plan
Parameters for all scenarios: TICKS_PER_SEC=10, TIME_SECONDS=3.

- Reset, then StartGame=1 for one cycle -> next edge Player=1, TurnActive=1, WhiteTime=3. After 10 edges WhiteTime=2; BlackTime stays 3.
- White idles 30 edges after start -> WhiteTime=0, GameOver=1, Winner=0, TurnActive=0 on the same edge. Further MoveDone pulses change nothing.
- MoveDone at edge 5 of white's turn -> Player=0 next edge, WhiteTime=3 (increment macro off). BlackTime=2 exactly 10 edges later.
- MoveDone and KingCaptured pulsed together during BLACK_TURN -> GameOver=1, Winner=0, Player stays 0.
- MoveDone on the edge where WhiteTime would go 1->0 -> no timeout; WhiteTime=1 (3 with CHESS_TIME_INCREMENT_EN, INCREMENT_SECONDS=2); Player=0.
- resetApp pulsed mid-BLACK_TURN between clock edges -> outputs return to reset values immediately; StartGame is needed to resume.

Source files
------------

// File: rtl/chess_turn_controller.sv
// Turn sequencer and per-side game clock for timed chess, running on the 10 Hz OutClock.
// Optional per-move time bonus is compiled in with CHESS_TIME_INCREMENT_EN.
module chess_turn_controller #(
   parameter int TICKS_PER_SEC     = 10,
   parameter int TIME_SECONDS      = 300,
   parameter int TIME_WIDTH        = 10,
   parameter int INCREMENT_SECONDS = 2
) (
   input  logic                  OutClock,
   input  logic                  resetApp,
   input  logic                  StartGame,
   input  logic                  MoveDone,
   input  logic                  KingCaptured,
   output logic                  Player,
   output logic                  TurnActive,
   output logic [TIME_WIDTH-1:0] WhiteTime,
   output logic [TIME_WIDTH-1:0] BlackTime,
   output logic                  GameOver,
   output logic                  Winner
);

   localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int TW1   = TIME_WIDTH + 1;
   localparam logic [SUB_W-1:0]      SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
   localparam logic [TIME_WIDTH-1:0] TIME_INIT = TIME_WIDTH'(TIME_SECONDS);

   typedef enum logic [1:0] {
      IDLE,
      WHITE_TURN,
      BLACK_TURN,
      GAME_OVER
   } state_t;

   state_t                state;
   logic [SUB_W-1:0]      SubCnt;
   logic [TIME_WIDTH-1:0] moverTime;
   logic                  subWrap;

   always_comb begin
      moverTime = Player ? WhiteTime : BlackTime;
      subWrap   = (SubCnt == SUB_LAST);
   end

`ifdef CHESS_TIME_INCREMENT_EN
   logic [TW1-1:0]        incSum;
   logic [TIME_WIDTH-1:0] bonusTime;

   always_comb begin
      incSum    = {1'b0, moverTime} + TW1'(INCREMENT_SECONDS);
      bonusTime = incSum[TIME_WIDTH] ? '1 : incSum[TIME_WIDTH-1:0];
   end
`endif

   always_ff @(posedge OutClock or posedge resetApp) begin
      if (resetApp) begin
         state      <= IDLE;
         Player     <= 1'b1;
         TurnActive <= 1'b0;
         GameOver   <= 1'b0;
         Winner     <= 1'b0;
         SubCnt     <= '0;
         WhiteTime  <= TIME_INIT;
         BlackTime  <= TIME_INIT;
      end else begin
         case (state)
            IDLE: begin
               if (StartGame) begin
                  state      <= WHITE_TURN;
                  Player     <= 1'b1;
                  TurnActive <= 1'b1;
                  SubCnt     <= '0;
               end
            end

            WHITE_TURN, BLACK_TURN: begin
               if (KingCaptured) begin
                  state      <= GAME_OVER;
                  TurnActive <= 1'b0;
                  GameOver   <= 1'b1;
                  Winner     <= Player;
               end else if (MoveDone) begin
                  // A decrement due on this edge is dropped: the new side starts a fresh second.
                  state  <= (state == WHITE_TURN) ? BLACK_TURN : WHITE_TURN;
                  Player <= ~Player;
                  SubCnt <= '0;
`ifdef CHESS_TIME_INCREMENT_EN
                  if (Player) WhiteTime <= bonusTime;
                  else        BlackTime <= bonusTime;
`endif
               end else begin
                  SubCnt <= subWrap ? '0 : SubCnt + 1'b1;
                  if (subWrap) begin
                     if (moverTime > TIME_WIDTH'(1)) begin
                        if (Player) WhiteTime <= moverTime - 1'b1;
                        else        BlackTime <= moverTime - 1'b1;
                     end else begin
                        if (Player) WhiteTime <= '0;
                        else        BlackTime <= '0;
                        state      <= GAME_OVER;
                        TurnActive <= 1'b0;
                        GameOver   <= 1'b1;
                        Winner     <= ~Player;
                     end
                  end
               end
            end

            GAME_OVER: begin
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
